// File: rtl/pc_pkg.sv
// Shared types for the program-counter unit: cause encoding and FSM states.
package pc_pkg;

    // Event source codes reported in cause.src.
    localparam logic [3:0] SRC_NONE   = 4'd0;
    localparam logic [3:0] SRC_EXC    = 4'd1;
    localparam logic [3:0] SRC_IRQ    = 4'd2;
    localparam logic [3:0] SRC_DOUBLE = 4'd3;

    typedef struct packed {
        logic [3:0] src;
        logic [3:0] idx;
    } cause_t;

    localparam cause_t CAUSE_NONE = '{src: SRC_NONE, idx: 4'd0};

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        HANDLER = 1'b1
    } pc_state_t;

    // Build a cause word from a source code and line index.
    function automatic cause_t mk_cause(input logic [3:0] src, input logic [3:0] idx);
        cause_t c;
        c.src = src;
        c.idx = idx;
        return c;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority interrupt encoder: bit 0 is the highest priority line.
// Produces a valid flag, the winning line index and its one-hot mask.
module irq_prio_enc #(
    parameter int N_IRQ = 4
) (
    input  logic [N_IRQ-1:0] irq_i,
    output logic             valid_o,
    output logic [3:0]       idx_o,
    output logic [N_IRQ-1:0] onehot_o
);

    // Scan from the lowest-priority line down so the lowest set bit wins.
    always_comb begin
        valid_o  = 1'b0;
        idx_o    = 4'd0;
        onehot_o = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (irq_i[i]) begin
                valid_o  = 1'b1;
                idx_o    = 4'(i);
                onehot_o = '0;
                onehot_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter unit: holds the fetch address and steers it between the
// sequential/branch target, exception/interrupt vectors and handler return.
// Optional build macro PC_VECTORED_IRQ_EN: each IRQ line gets its own entry
// at IRQ_VEC + 4*idx; otherwise all lines share IRQ_VEC.
module pc_ctrl
    import pc_pkg::*;
#(
    parameter int           W         = 32,
    parameter int           N_IRQ     = 4,
    parameter logic [W-1:0] RESET_VEC = W'(32'h8000_0000),
    parameter logic [W-1:0] EXC_VEC   = W'(32'h8000_0004),
    parameter logic [W-1:0] IRQ_VEC   = W'(32'h8000_0008)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [W-1:0]     pcin,
    input  logic             exception,
    input  logic [N_IRQ-1:0] irq,
    input  logic             eret,
    output logic [W-1:0]     ia,
    output logic [W-1:0]     epc,
    output cause_t           cause,
    output logic             in_handler,
    output logic [N_IRQ-1:0] irq_ack
);

    localparam logic [0:0] ST_RUN     = 1'(RUN);
    localparam logic [0:0] ST_HANDLER = 1'(HANDLER);

    logic [0:0]       state_q, state_d;
    logic [W-1:0]     ia_q, ia_d;
    logic [W-1:0]     epc_q, epc_d;
    cause_t           cause_q, cause_d;
    logic [N_IRQ-1:0] ack_q, ack_d;
    logic [W-1:0]     nxt_pc;
    logic [W-1:0]     irq_vec;

    logic             irq_vld;
    logic [3:0]       irq_idx;
    logic [N_IRQ-1:0] irq_oh;

    irq_prio_enc #(.N_IRQ(N_IRQ)) u_prio (
        .irq_i    (irq),
        .valid_o  (irq_vld),
        .idx_o    (irq_idx),
        .onehot_o (irq_oh)
    );

`ifdef PC_VECTORED_IRQ_EN
    // Per-line entry points; the add wraps naturally at W bits.
    assign irq_vec = IRQ_VEC + (W'(irq_idx) << 2);
`else
    // Single shared entry; the handler decodes cause.idx.
    assign irq_vec = IRQ_VEC;
`endif

    // Prioritised next-PC selection and event capture.
    always_comb begin
        state_d = state_q;
        nxt_pc  = ia_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        ack_d   = '0;
        if (exception) begin
            nxt_pc  = EXC_VEC;
            state_d = ST_HANDLER;
            if (state_q == ST_HANDLER) begin
                // Fault inside a handler keeps the original return address.
                cause_d = mk_cause(SRC_DOUBLE, 4'd0);
            end else begin
                epc_d   = ia_q;
                cause_d = mk_cause(SRC_EXC, 4'd0);
            end
        end else if (irq_vld && state_q == ST_RUN) begin
            nxt_pc  = irq_vec;
            epc_d   = {pcin[W-1:2], 2'b00};
            cause_d = mk_cause(SRC_IRQ, irq_idx);
            ack_d   = irq_oh;
            state_d = ST_HANDLER;
        end else if (eret && state_q == ST_HANDLER) begin
            nxt_pc  = epc_q;
            state_d = ST_RUN;
        end else if (!stall) begin
            nxt_pc  = pcin;
        end
        ia_d = {nxt_pc[W-1:2], 2'b00};
    end

    logic unused_lsb;
    assign unused_lsb = ^nxt_pc[1:0];

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            ia_q    <= RESET_VEC;
            epc_q   <= '0;
            cause_q <= CAUSE_NONE;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            ia_q    <= ia_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            ack_q   <= ack_d;
        end
    end

    assign ia         = ia_q;
    assign epc        = epc_q;
    assign cause      = cause_q;
    assign in_handler = (state_q == ST_HANDLER);
    assign irq_ack    = ack_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed testbench for pc_ctrl with hand-computed expected values.
module tb_pc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [31:0] pcin;
    logic        exception;
    logic [3:0]  irq;
    logic        eret;
    logic [31:0] ia;
    logic [31:0] epc;
    logic [7:0]  cause;
    logic        in_handler;
    logic [3:0]  irq_ack;

    int n_chk = 0;
    int n_err = 0;

`ifdef PC_VECTORED_IRQ_EN
    localparam logic [31:0] IRQ1_VEC = 32'h8000_000C;
`else
    localparam logic [31:0] IRQ1_VEC = 32'h8000_0008;
`endif
    localparam logic [31:0] IRQ0_VEC = 32'h8000_0008;

    pc_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .pcin       (pcin),
        .exception  (exception),
        .irq        (irq),
        .eret       (eret),
        .ia         (ia),
        .epc        (epc),
        .cause      (cause),
        .in_handler (in_handler),
        .irq_ack    (irq_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_ia, input logic [31:0] e_epc,
                             input logic [7:0] e_cause, input logic e_hnd, input logic [3:0] e_ack);
        check({tag, ".ia"},    ia,         e_ia);
        check({tag, ".epc"},   epc,        e_epc);
        check({tag, ".cause"}, 32'(cause), 32'(e_cause));
        check({tag, ".hnd"},   32'(in_handler), 32'(e_hnd));
        check({tag, ".ack"},   32'(irq_ack),    32'(e_ack));
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; pcin = 32'h0000_1234;
        exception = 1'b0; irq = 4'b0; eret = 1'b0;
        #12 reset = 1'b0;
        tick();
        check("seq_pcin", ia, 32'h0000_1234);

        // T1: asynchronous reset between edges
        #3 reset = 1'b1;
        #1 check_all("t1_reset", 32'h8000_0000, 32'h0, 8'h00, 1'b0, 4'b0);
        #1 reset = 1'b0;

        // T2: two lines pending, line 1 wins
        pcin = 32'h8000_0010; irq = 4'b0110;
        tick();
        check_all("t2_take", IRQ1_VEC, 32'h8000_0010, 8'h21, 1'b1, 4'b0010);
        irq = 4'b0; pcin = 32'h8000_0014;
        tick();
        check_all("t2_after", 32'h8000_0014, 32'h8000_0010, 8'h21, 1'b1, 4'b0000);

        // T3: IRQ masked inside handler, taken after eret
        irq = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            pcin = 32'h8000_0100 + 32'(4 * k);
            tick();
            check("t3_mask.ia", ia, 32'h8000_0100 + 32'(4 * k));
            check("t3_mask.ack", 32'(irq_ack), 32'h0);
        end
        eret = 1'b1; pcin = 32'h8000_010C;
        tick();
        check_all("t3_eret", 32'h8000_0010, 32'h8000_0010, 8'h21, 1'b0, 4'b0);
        eret = 1'b0; pcin = 32'h8000_0010;
        tick();
        check_all("t3_irq0", IRQ0_VEC, 32'h8000_0010, 8'h20, 1'b1, 4'b0001);
        irq = 4'b0; eret = 1'b1;
        tick();
        check_all("t3_ret", 32'h8000_0010, 32'h8000_0010, 8'h20, 1'b0, 4'b0);
        eret = 1'b0;

        // T4: exception beats IRQ and stall
        pcin = 32'h8000_0020;
        tick();
        check("t4_seq", ia, 32'h8000_0020);
        exception = 1'b1; irq = 4'b0001; stall = 1'b1; pcin = 32'h8000_0024;
        tick();
        check_all("t4_exc", 32'h8000_0004, 32'h8000_0020, 8'h10, 1'b1, 4'b0);
        exception = 1'b0; stall = 1'b0; eret = 1'b1; pcin = 32'h8000_0028;
        tick();
        check_all("t4_eret", 32'h8000_0020, 32'h8000_0020, 8'h10, 1'b0, 4'b0);
        eret = 1'b0; pcin = 32'h8000_0030;
        tick();
        check_all("t4_irq", IRQ0_VEC, 32'h8000_0030, 8'h20, 1'b1, 4'b0001);
        irq = 4'b0;

        // T5: nested exception keeps epc
        exception = 1'b1; pcin = 32'h8000_0034;
        tick();
        check_all("t5_double", 32'h8000_0004, 32'h8000_0030, 8'h30, 1'b1, 4'b0);
        exception = 1'b0; eret = 1'b1;
        tick();
        check_all("t5_ret", 32'h8000_0030, 32'h8000_0030, 8'h30, 1'b0, 4'b0);

        // T6: stall holds ia; eret in RUN is ignored
        eret = 1'b0; stall = 1'b1; pcin = 32'h8000_0040;
        tick();
        check("t6_stall0", ia, 32'h8000_0030);
        pcin = 32'h8000_0044;
        tick();
        check("t6_stall1", ia, 32'h8000_0030);
        stall = 1'b0; eret = 1'b1; pcin = 32'h8000_0050;
        tick();
        check_all("t6_eret_run", 32'h8000_0050, 32'h8000_0030, 8'h30, 1'b0, 4'b0);
        eret = 1'b0;

        // Low address bits are dropped
        pcin = 32'h8000_0063;
        tick();
        check("align", ia, 32'h8000_0060);

        // Reset while in a handler clears everything
        exception = 1'b1;
        tick();
        check("pre_rst.hnd", 32'(in_handler), 32'h1);
        exception = 1'b0;
        #3 reset = 1'b1;
        #1 check_all("rst_hnd", 32'h8000_0000, 32'h0, 8'h00, 1'b0, 4'b0);
        #1 reset = 1'b0;
        pcin = 32'h8000_0070;
        tick();
        check_all("post_rst", 32'h8000_0070, 32'h0, 8'h00, 1'b0, 4'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
